ms_tick_sched: RTL and testbench

// - Shares one countdown timer, clocked by the 1 ms tick pulse, between N_CH requesters.
// - Each requester asks for a timeout in milliseconds; the block grants round-robin, counts ticks, and pulses done.
// - Sits between the 1 ms pulse generator and the FSMs needing delays (debounce, display hold, beeper timing).

---
 rtl/ms_tick_sched_pkg.sv | 14 +
 rtl/ms_tick_sched_rr_arbiter.sv | 32 +++
 rtl/ms_tick_sched.sv | 116 +++++++++++
 tb/tb_ms_tick_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ms_tick_sched_pkg.sv
// Shared types and default sizing for the ms_tick_sched shared countdown timer.
package ms_tick_sched_pkg;

  localparam int ST_W      = 2;
  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ms_tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int j;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_CH;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_tick_sched.sv
// One 1 ms countdown timer shared round-robin between N_CH requesters.
// Build option MS_TICK_SCHED_CANCEL_EN: dropping the granted request during RUN aborts the interval.
//
// state | meaning
// IDLE  | no interval active, arbitrating pending requests
// RUN   | interval granted, o_remain counts down on i_pls_1k
// DONE  | one-cycle expiry, o_done pulses, pointer advances
module ms_tick_sched
  import ms_tick_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pls_1k,
  input  logic [N_CH-1:0]       i_req,
  input  logic [N_CH*CNT_W-1:0] i_dur,
  output logic [N_CH-1:0]       o_gnt,
  output logic [N_CH-1:0]       o_done,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_remain
);

  localparam int PTR_W = $clog2(N_CH);

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  cur_idx;
  logic [PTR_W-1:0]  nxt_ptr;
  logic              first_run;
  logic              cancel;

  logic [N_CH-1:0]   arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    nxt_ptr = (int'(cur_idx) == N_CH - 1) ? '0 : cur_idx + 1'b1;
  end

`ifdef MS_TICK_SCHED_CANCEL_EN
  assign cancel = ~i_req[cur_idx];
`else
  assign cancel = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_gnt     <= '0;
      o_done    <= '0;
      o_busy    <= 1'b0;
      o_remain  <= '0;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      first_run <= 1'b0;
    end else begin
      o_done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state     <= RUN;
            o_gnt     <= arb_gnt;
            cur_idx   <= arb_idx;
            o_remain  <= i_dur[arb_idx*CNT_W +: CNT_W];
            o_busy    <= 1'b1;
            first_run <= 1'b1;
          end
        end
        RUN: begin
          first_run <= 1'b0;
          if (cancel) begin
            state    <= IDLE;
            o_gnt    <= '0;
            o_remain <= '0;
            o_busy   <= 1'b0;
            rr_ptr   <= nxt_ptr;
          end else if (!first_run) begin
            // A tick arriving in the grant cycle itself is deliberately dropped.
            if (o_remain == '0) begin
              state  <= DONE;
              o_done <= o_gnt;
              o_gnt  <= '0;
            end else if (i_pls_1k) begin
              o_remain <= o_remain - 1'b1;
              if (o_remain == CNT_W'(1)) begin
                state  <= DONE;
                o_done <= o_gnt;
                o_gnt  <= '0;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          rr_ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_tick_sched.sv
// Directed bench for ms_tick_sched: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_ms_tick_sched;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_pls_1k;
  logic [N_CH-1:0]       i_req;
  logic [N_CH*CNT_W-1:0] i_dur;
  logic [N_CH-1:0]       o_gnt;
  logic [N_CH-1:0]       o_done;
  logic                  o_busy;
  logic [CNT_W-1:0]      o_remain;

  int checks = 0;
  int errors = 0;

  ms_tick_sched #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_pls_1k (i_pls_1k),
    .i_req    (i_req),
    .i_dur    (i_dur),
    .o_gnt    (o_gnt),
    .o_done   (o_done),
    .o_busy   (o_busy),
    .o_remain (o_remain)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] dur;
    logic        pls;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] remain;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [3:0] req, input logic [15:0] dur, input logic pls,
                              input logic [3:0] gnt, input logic [3:0] done, input logic busy,
                              input logic [15:0] remain);
    vec_t v;
    v.req = req; v.dur = dur; v.pls = pls;
    v.gnt = gnt; v.done = done; v.busy = busy; v.remain = remain;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Waits for any grant; reports the cycles it took.
  task automatic wait_gnt(input string name, input logic [3:0] exp, output int cyc);
    cyc = 0;
    i_pls_1k = 1'b0;
    while (o_gnt == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    if (o_gnt == '0) begin
      errors++;
      checks++;
      $display("FAIL %s: no grant within 40 cycles, expected %0h", name, exp);
    end else begin
      chk(name, 32'(o_gnt), 32'(exp));
    end
  endtask

  // Ticks every other cycle until a done pulse appears.
  task automatic wait_done(input string name, input logic [3:0] exp);
    int c;
    c = 0;
    while (c < 40) begin
      i_pls_1k = c[0];
      step();
      c++;
      if (o_done != '0) break;
    end
    i_pls_1k = 1'b0;
    chk(name, 32'(o_done), 32'(exp));
  endtask

  initial begin
    int cyc;
    logic [3:0] order[5];

    i_rst    = 1'b1;
    i_pls_1k = 1'b0;
    i_req    = '0;
    i_dur    = '0;
    repeat (3) step();
    chk("reset_gnt", 32'(o_gnt), 0);
    chk("reset_done", 32'(o_done), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_remain", 32'(o_remain), 0);
    i_rst = 1'b0;

    // T2 single ch2 dur3, T4 ch1 dur0, T5 ch3 dur2 with ticks in arb and grant cycles
    vecs[0]  = mk(4'b0100, 16'd3, 1'b0, 4'b0100, 4'b0000, 1'b1, 16'd3);
    vecs[1]  = mk(4'b0100, 16'd3, 1'b0, 4'b0100, 4'b0000, 1'b1, 16'd3);
    vecs[2]  = mk(4'b0100, 16'd3, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd2);
    vecs[3]  = mk(4'b0100, 16'd3, 1'b0, 4'b0100, 4'b0000, 1'b1, 16'd2);
    vecs[4]  = mk(4'b0100, 16'd3, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd1);
    vecs[5]  = mk(4'b0100, 16'd3, 1'b1, 4'b0000, 4'b0100, 1'b1, 16'd0);
    vecs[6]  = mk(4'b0000, 16'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0);
    vecs[7]  = mk(4'b0010, 16'd0, 1'b0, 4'b0010, 4'b0000, 1'b1, 16'd0);
    vecs[8]  = mk(4'b0010, 16'd0, 1'b0, 4'b0010, 4'b0000, 1'b1, 16'd0);
    vecs[9]  = mk(4'b0010, 16'd0, 1'b0, 4'b0000, 4'b0010, 1'b1, 16'd0);
    vecs[10] = mk(4'b0000, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0);
    vecs[11] = mk(4'b1000, 16'd2, 1'b1, 4'b1000, 4'b0000, 1'b1, 16'd2);
    vecs[12] = mk(4'b1000, 16'd2, 1'b1, 4'b1000, 4'b0000, 1'b1, 16'd2);
    vecs[13] = mk(4'b1000, 16'd7, 1'b1, 4'b1000, 4'b0000, 1'b1, 16'd1);
    vecs[14] = mk(4'b1000, 16'd7, 1'b0, 4'b1000, 4'b0000, 1'b1, 16'd1);
    vecs[15] = mk(4'b1000, 16'd7, 1'b1, 4'b0000, 4'b1000, 1'b1, 16'd0);
    vecs[16] = mk(4'b0000, 16'd7, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0);

    for (int i = 0; i < 17; i++) begin
      i_req    = vecs[i].req;
      i_dur    = {4{vecs[i].dur}};
      i_pls_1k = vecs[i].pls;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(o_gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(o_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_remain", i), 32'(o_remain), 32'(vecs[i].remain));
    end
    i_pls_1k = 1'b0;

    // T3 round-robin: all four request dur1; ch0 re-requests while ch3 still pending
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    i_dur = {4{16'd1}};
    i_req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_gnt($sformatf("rr%0d_gnt", s), order[s], cyc);
      if (s == 1) begin
        chk("rr_regrant_latency", 32'(cyc), 2);
        i_req[0] = 1'b1;
      end
      wait_done($sformatf("rr%0d_done", s), order[s]);
      i_req = i_req & ~order[s];
    end

    // T1 reset mid-run: pointer is now 1, so ch0 winning afterwards proves the pointer cleared
    step();
    i_dur = {4{16'd5}};
    i_req = 4'b0010;
    wait_gnt("t1_gnt", 4'b0010, cyc);
    step();
    i_pls_1k = 1'b1;
    step();
    step();
    i_pls_1k = 1'b0;
    chk("t1_remain_mid", 32'(o_remain), 3);
    i_rst = 1'b1;
    i_req = 4'b0011;
    step();
    chk("t1_rst_gnt", 32'(o_gnt), 0);
    chk("t1_rst_busy", 32'(o_busy), 0);
    chk("t1_rst_remain", 32'(o_remain), 0);
    chk("t1_rst_done", 32'(o_done), 0);
    i_rst = 1'b0;
    wait_gnt("t1_ch0_wins", 4'b0001, cyc);
    i_rst = 1'b1;
    i_req = '0;
    step();
    i_rst = 1'b0;
    step();

    // T6 ch0 dur10, request dropped after 4 ticks
    i_dur = {4{16'd10}};
    i_req = 4'b0001;
    wait_gnt("t6_gnt", 4'b0001, cyc);
    step();
    i_pls_1k = 1'b1;
    repeat (4) step();
    i_pls_1k = 1'b0;
    chk("t6_remain_4", 32'(o_remain), 6);
    i_req = '0;
`ifdef MS_TICK_SCHED_CANCEL_EN
    step();
    chk("t6_cancel_gnt", 32'(o_gnt), 0);
    chk("t6_cancel_remain", 32'(o_remain), 0);
    chk("t6_cancel_busy", 32'(o_busy), 0);
    chk("t6_cancel_done", 32'(o_done), 0);
    i_pls_1k = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t6_cancel_quiet%0d", i), 32'(o_done), 0);
    end
    i_pls_1k = 1'b0;
`else
    for (int i = 0; i < 6; i++) begin
      i_pls_1k = 1'b1;
      step();
      i_pls_1k = 1'b0;
      chk($sformatf("t6_remain_t%0d", i + 5), 32'(o_remain), 32'(5 - i));
      chk($sformatf("t6_done_t%0d", i + 5), 32'(o_done), (i == 5) ? 32'h1 : 32'h0);
    end
    step();
    chk("t6_idle_busy", 32'(o_busy), 0);
    chk("t6_idle_done", 32'(o_done), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
